// File: rtl/pixel_stream_quantizer_pkg.sv
// Shared frame geometry, fixed-point format and FSM encoding for the pixel
// stream quantizer and its combinational sample-to-pixel stage.
package pixel_stream_quantizer_pkg;

  localparam int IMG_WIDTH   = 28;
  localparam int IMG_HEIGHT  = 28;
  localparam int PIXEL_COUNT = IMG_WIDTH * IMG_HEIGHT;
  localparam int DATA_WIDTH  = 16;
  localparam int FRAC_BITS   = 8;
  localparam int PIXEL_WIDTH = 8;

  function automatic int calc_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int ROW_W = calc_clog2(IMG_HEIGHT);
  localparam int COL_W = calc_clog2(IMG_WIDTH);
  localparam int IDX_W = calc_clog2(PIXEL_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/pixel_stream_quantizer_q_to_pixel.sv
// Combinational saturating quantizer: maps a signed Q-format sample in
// [-1.0, +1.0] onto an 8-bit unsigned pixel in [0, 255], truncating.
module q_to_pixel #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic [DATA_WIDTH-1:0] sample_in,
  output logic [7:0]            pixel_out
);

  localparam logic [DATA_WIDTH:0]   ONE  = {{DATA_WIDTH{1'b0}}, 1'b1} << FRAC_BITS;
  localparam logic [DATA_WIDTH+8:0] GAIN = (DATA_WIDTH + 9)'(255);

  logic [DATA_WIDTH:0]   shifted_sum;
  logic [DATA_WIDTH+8:0] scaled;
  logic [DATA_WIDTH+8:0] level;

  // Sign-extended add cannot overflow, so bit DATA_WIDTH is the sign of x + 1.0.
  always_comb begin
    shifted_sum = {sample_in[DATA_WIDTH-1], sample_in} + ONE;
    scaled      = {9'd0, shifted_sum[DATA_WIDTH-1:0]} * GAIN;
    level       = scaled >> (FRAC_BITS + 1);
    if (shifted_sum[DATA_WIDTH] || (shifted_sum == '0)) begin
      pixel_out = 8'd0;
    end else if (level > GAIN) begin
      pixel_out = 8'hFF;
    end else begin
      pixel_out = level[7:0];
    end
  end

endmodule

// File: rtl/pixel_stream_quantizer.sv
// Latches a full feature frame on start and streams it out as quantized
// pixels over valid/ready, tagged with row/col/sof/last.
module pixel_stream_quantizer
  import pixel_stream_quantizer_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] vector_in,
  output logic [PIXEL_WIDTH-1:0]            pix_data,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic [ROW_W-1:0]                  pix_row,
  output logic [COL_W-1:0]                  pix_col,
  output logic                              pix_sof,
  output logic                              pix_last,
  output logic                              busy,
  output logic                              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXEL_COUNT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  state_t                                 state_q, state_d;
  logic [PIXEL_COUNT-1:0][DATA_WIDTH-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]                       idx_q, idx_d;
  logic [ROW_W-1:0]                       row_q, row_d;
  logic [COL_W-1:0]                       col_q, col_d;
  logic [PIXEL_WIDTH-1:0]                 data_q, data_d;
  logic                                   valid_q, valid_d;
  logic                                   sof_q, sof_d;
  logic                                   last_q, last_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;

  logic [IDX_W-1:0]       next_idx;
  logic [DATA_WIDTH-1:0]  sample;
  logic [PIXEL_WIDTH-1:0] quant_pix;

  // Pixel 0 is quantized straight from vector_in so it is ready the cycle after start.
  assign next_idx = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
  assign sample   = (state_q == ST_IDLE) ? vector_in[DATA_WIDTH-1:0] : frame_q[next_idx];

  q_to_pixel #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_quant (
    .sample_in (sample),
    .pixel_out (quant_pix)
  );

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          frame_d = vector_in;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          data_d  = quant_pix;
          valid_d = 1'b1;
          sof_d   = 1'b1;
          last_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_STREAM: begin
        if (pix_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            data_d  = '0;
            valid_d = 1'b0;
            sof_d   = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = next_idx;
            data_d = quant_pix;
            sof_d  = 1'b0;
            last_d = (next_idx == LAST_IDX);
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + ROW_W'(1);
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pix_data  = data_q;
  assign pix_valid = valid_q;
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign pix_sof   = sof_q;
  assign pix_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pixel_stream_quantizer.sv
// Directed bench for pixel_stream_quantizer: reset, latency, quantization
// corners, backpressure, ignored starts and mid-frame abort.
module tb_pixel_stream_quantizer;
  import pixel_stream_quantizer_pkg::*;

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              start;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] vector_in;
  logic [PIXEL_WIDTH-1:0]            pix_data;
  logic                              pix_valid;
  logic                              pix_ready;
  logic [ROW_W-1:0]                  pix_row;
  logic [COL_W-1:0]                  pix_col;
  logic                              pix_sof;
  logic                              pix_last;
  logic                              busy;
  logic                              done;

  int checks = 0;
  int errors = 0;
  int exp_pix [PIXEL_COUNT];
  int cycles;

  always #5 clk = ~clk;

  pixel_stream_quantizer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .vector_in (vector_in),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_row   (pix_row),
    .pix_col   (pix_col),
    .pix_sof   (pix_sof),
    .pix_last  (pix_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input int k, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s (k=%0d): observed %0h expected %0h", tag, k, observed, expected);
    end
  endtask

  // Independent reference used only for the ramp frames.
  function automatic int model_pixel(input logic [15:0] x);
    int s;
    s = int'($signed(x)) + 256;
    if (s <= 0) return 0;
    s = (s * 255) / 512;
    return (s > 255) ? 255 : s;
  endfunction

  task automatic set_sample(input int k, input logic [15:0] v);
    vector_in[k*DATA_WIDTH +: DATA_WIDTH] = v;
  endtask

  task automatic fill_const(input logic [15:0] v, input int pix);
    for (int k = 0; k < PIXEL_COUNT; k++) begin
      set_sample(k, v);
      exp_pix[k] = pix;
    end
  endtask

  task automatic fill_ramp(input int offset);
    for (int k = 0; k < PIXEL_COUNT; k++) begin
      set_sample(k, 16'(k - offset));
      exp_pix[k] = model_pixel(16'(k - offset));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pix_data"}, -1, 32'(pix_data), 0);
    check({tag, " pix_valid"}, -1, 32'(pix_valid), 0);
    check({tag, " pix_row"}, -1, 32'(pix_row), 0);
    check({tag, " pix_col"}, -1, 32'(pix_col), 0);
    check({tag, " pix_sof"}, -1, 32'(pix_sof), 0);
    check({tag, " pix_last"}, -1, 32'(pix_last), 0);
    check({tag, " busy"}, -1, 32'(busy), 0);
    check({tag, " done"}, -1, 32'(done), 0);
  endtask

  task automatic check_pixel(input int k);
    check("pix_valid", k, 32'(pix_valid), 1);
    check("busy", k, 32'(busy), 1);
    check("done", k, 32'(done), 0);
    check("pix_data", k, 32'(pix_data), exp_pix[k]);
    check("pix_row", k, 32'(pix_row), k / IMG_WIDTH);
    check("pix_col", k, 32'(pix_col), k % IMG_WIDTH);
    check("pix_sof", k, 32'(pix_sof), (k == 0) ? 1 : 0);
    check("pix_last", k, 32'(pix_last), (k == PIXEL_COUNT - 1) ? 1 : 0);
  endtask

  // Called on a negedge; the frame is accepted on the following posedge.
  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consumes one frame from pixel 0, then checks the done cycle and the return to idle.
  task automatic stream_frame(input bit rand_ready, input int poke_k, input bit poke_done,
                              output int n_cycles);
    int  k;
    bit  rdy;
    k = 0;
    n_cycles = 0;
    while (k < PIXEL_COUNT && n_cycles < 4 * PIXEL_COUNT) begin
      check_pixel(k);
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_ready = rdy;
      start = (k == poke_k);
      @(negedge clk);
      start = 1'b0;
      if (rdy) k++;
      n_cycles++;
    end
    check("frame_complete", k, 32'(k), PIXEL_COUNT);
    check("done_pulse", -1, 32'(done), 1);
    check("valid_after_last", -1, 32'(pix_valid), 0);
    check("busy_after_last", -1, 32'(busy), 0);
    pix_ready = 1'b1;
    start = poke_done;
    @(negedge clk);
    start = 1'b0;
    check("done_single", -1, 32'(done), 0);
    check("idle_valid", -1, 32'(pix_valid), 0);
    check("idle_busy", -1, 32'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    start = 1'b0;
    pix_ready = 1'b1;
    fill_const(16'h0100, 255);

    // Reset asserted between clock edges must clear outputs immediately.
    #2 rst = 1'b1;
    start = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    check_all_zero("start_during_reset");
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    $display("[TB] Frame of +1.0 samples, ready held high");
    start_frame();
    stream_frame(1'b0, -1, 1'b0, cycles);
    check("latency_cycles", -1, 32'(cycles), PIXEL_COUNT);

    $display("[TB] Quantization corners");
    fill_const(16'h0100, 255);
    set_sample(0, 16'hFE00); exp_pix[0] = 0;
    set_sample(1, 16'hFF80); exp_pix[1] = 63;
    set_sample(2, 16'h0000); exp_pix[2] = 127;
    set_sample(3, 16'h0080); exp_pix[3] = 191;
    set_sample(4, 16'h0100); exp_pix[4] = 255;
    set_sample(5, 16'h7FFF); exp_pix[5] = 255;
    set_sample(6, 16'h8000); exp_pix[6] = 0;
    start_frame();
    stream_frame(1'b0, -1, 1'b0, cycles);

    $display("[TB] Ramp frame with random backpressure");
    fill_ramp(392);
    start_frame();
    stream_frame(1'b1, -1, 1'b0, cycles);

    $display("[TB] Start pulses mid-frame and in done cycle are ignored");
    fill_ramp(392);
    start_frame();
    fill_const(16'h0000, 127);
    fill_ramp(392);
    for (int k = 0; k < PIXEL_COUNT; k++) set_sample(k, 16'h0000);
    stream_frame(1'b0, 100, 1'b1, cycles);
    @(negedge clk);
    check("no_restart_valid", -1, 32'(pix_valid), 0);
    check("no_restart_busy", -1, 32'(busy), 0);
    fill_const(16'h0000, 127);
    start_frame();
    stream_frame(1'b1, -1, 1'b0, cycles);

    $display("[TB] Reset mid-frame aborts without done");
    fill_const(16'h0080, 191);
    start_frame();
    for (int k = 0; k < 400; k++) begin
      check_pixel(k);
      @(negedge clk);
    end
    check_pixel(400);
    #1 rst = 1'b1;
    #1 check_all_zero("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", -1, 32'(done), 0);
      check("abort_no_valid", -1, 32'(pix_valid), 0);
    end
    fill_ramp(100);
    start_frame();
    stream_frame(1'b0, -1, 1'b0, cycles);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
